// File: rtl/tank_move_ctl_if.sv
// Signal bundle between the frame/key/hit sources and the tank motion controller.
// The master side drives frame timing, keys and hit; the slave (controller) drives
// the sprite position, facing and visibility back to the drawing stage.
interface tank_move_ctl_if;
  logic       vblnk;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       hit;
  logic [9:0] posX;
  logic [9:0] posY;
  logic [1:0] direction;
  logic       select;
  logic       frame_done;

  modport master (
    output vblnk, key_up, key_down, key_left, key_right, hit,
    input  posX, posY, direction, select, frame_done
  );

  modport slave (
    input  vblnk, key_up, key_down, key_left, key_right, hit,
    output posX, posY, direction, select, frame_done
  );
endinterface

// File: rtl/tank_move_ctl.sv
// Per-frame motion and lifecycle controller for one player tank.
// A frame tick (vblnk rising edge) runs IDLE -> EVAL -> COMMIT; EVAL computes the
// candidate state from the keys, COMMIT loads it onto the registered outputs.
module tank_move_ctl #(
  parameter int SCREEN_W       = 800,
  parameter int SCREEN_H       = 600,
  parameter int TANK_LONG      = 64,
  parameter int TANK_SHORT     = 48,
  parameter int STEP           = 2,
  parameter int INIT_X         = 376,
  parameter int INIT_Y         = 268,
  parameter int RESPAWN_FRAMES = 120
) (
  input logic           clk,
  input logic           rst,
  tank_move_ctl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

  localparam int CW = $clog2(RESPAWN_FRAMES + 1);

  // 11-bit copies so edge arithmetic never wraps.
  localparam logic [10:0]   W11         = 11'(SCREEN_W);
  localparam logic [10:0]   H11         = 11'(SCREEN_H);
  localparam logic [10:0]   LONG11      = 11'(TANK_LONG);
  localparam logic [10:0]   SHORT11     = 11'(TANK_SHORT);
  localparam logic [10:0]   STEP11      = 11'(STEP);
  localparam logic [9:0]    STEP10      = 10'(STEP);
  localparam logic [9:0]    INIT_X10    = 10'(INIT_X);
  localparam logic [9:0]    INIT_Y10    = 10'(INIT_Y);
  localparam logic [CW-1:0] RESPAWN_CNT = CW'(RESPAWN_FRAMES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t          state;
  logic            vblnk_d;
  logic            hit_latch;
  logic [CW-1:0]   death_cnt;
  logic [9:0]      pos_x;
  logic [9:0]      pos_y;
  logic [1:0]      dir;
  logic            alive;
  logic            done;

  // Candidate state captured in EVAL, applied in COMMIT.
  logic [9:0]      cand_x;
  logic [9:0]      cand_y;
  logic [1:0]      cand_dir;
  logic            cand_sel;
  logic [CW-1:0]   cand_cnt;
  logic            cand_kill;

  // Combinational next-state values for the frame being evaluated.
  logic            req_valid;
  logic [1:0]      req_dir;
  logic [10:0]     fw_req;
  logic [10:0]     fh_req;
  logic [10:0]     lim_x;
  logic [10:0]     lim_y;
  logic [10:0]     sum_x;
  logic [10:0]     sum_y;
  logic [9:0]      nxt_x;
  logic [9:0]      nxt_y;
  logic [1:0]      nxt_dir;
  logic            nxt_sel;
  logic [CW-1:0]   nxt_cnt;
  logic            nxt_kill;

  logic            tick;
  assign tick = bus.vblnk & ~vblnk_d;

  // Frame rules: kill, dead countdown, respawn, then turn or move with clamping.
  always_comb begin
    req_valid = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
    if (bus.key_up)          req_dir = 2'd0;
    else if (bus.key_down)   req_dir = 2'd1;
    else if (bus.key_left)   req_dir = 2'd2;
    else                     req_dir = 2'd3;
    // Footprint of the requested facing; equals the current one when moving straight.
    fw_req   = req_dir[1] ? LONG11 : SHORT11;
    fh_req   = req_dir[1] ? SHORT11 : LONG11;
    lim_x    = W11 - fw_req;
    lim_y    = H11 - fh_req;
    sum_x    = {1'b0, pos_x} + STEP11;
    sum_y    = {1'b0, pos_y} + STEP11;
    nxt_x    = pos_x;
    nxt_y    = pos_y;
    nxt_dir  = dir;
    nxt_sel  = alive;
    nxt_cnt  = death_cnt;
    nxt_kill = 1'b0;
    if (alive && hit_latch) begin
      nxt_sel  = 1'b0;
      nxt_cnt  = RESPAWN_CNT;
      nxt_kill = 1'b1;
    end else if (!alive && death_cnt > CNT_ONE) begin
      nxt_cnt = death_cnt - CNT_ONE;
    end else if (!alive) begin
      nxt_x   = INIT_X10;
      nxt_y   = INIT_Y10;
      nxt_dir = 2'd0;
      nxt_sel = 1'b1;
      nxt_cnt = '0;
    end else if (req_valid) begin
      if (req_dir != dir) begin
        // Turn in place, pulling the sprite back on screen for the new footprint.
        nxt_dir = req_dir;
        nxt_x   = ({1'b0, pos_x} > lim_x) ? lim_x[9:0] : pos_x;
        nxt_y   = ({1'b0, pos_y} > lim_y) ? lim_y[9:0] : pos_y;
      end else begin
        case (req_dir)
          2'd0:    nxt_y = ({1'b0, pos_y} >= STEP11) ? pos_y - STEP10 : 10'd0;
          2'd1:    nxt_y = (sum_y > lim_y) ? lim_y[9:0] : sum_y[9:0];
          2'd2:    nxt_x = ({1'b0, pos_x} >= STEP11) ? pos_x - STEP10 : 10'd0;
          default: nxt_x = (sum_x > lim_x) ? lim_x[9:0] : sum_x[9:0];
        endcase
      end
    end
  end

  // Frame FSM with registered outputs, edge detector and hit latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vblnk_d   <= 1'b0;
      hit_latch <= 1'b0;
      death_cnt <= '0;
      pos_x     <= INIT_X10;
      pos_y     <= INIT_Y10;
      dir       <= 2'd0;
      alive     <= 1'b1;
      done      <= 1'b0;
      cand_x    <= INIT_X10;
      cand_y    <= INIT_Y10;
      cand_dir  <= 2'd0;
      cand_sel  <= 1'b1;
      cand_cnt  <= '0;
      cand_kill <= 1'b0;
    end else begin
      vblnk_d <= bus.vblnk;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) state <= EVAL;
        end
        EVAL: begin
          cand_x    <= nxt_x;
          cand_y    <= nxt_y;
          cand_dir  <= nxt_dir;
          cand_sel  <= nxt_sel;
          cand_cnt  <= nxt_cnt;
          cand_kill <= nxt_kill;
          state     <= COMMIT;
        end
        COMMIT: begin
          pos_x     <= cand_x;
          pos_y     <= cand_y;
          dir       <= cand_dir;
          alive     <= cand_sel;
          death_cnt <= cand_cnt;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A committed kill consumes the latch; hits while hidden are ignored.
      if (state == COMMIT && cand_kill) hit_latch <= 1'b0;
      else if (bus.hit && alive)        hit_latch <= 1'b1;
    end
  end

  assign bus.posX       = pos_x;
  assign bus.posY       = pos_y;
  assign bus.direction  = dir;
  assign bus.select     = alive;
  assign bus.frame_done = done;

endmodule

// File: tb/tb_tank_move_ctl.sv
// Testbench for tank_move_ctl: directed frame table, dead/respawn and edge
// sequences, reset during evaluation, and random frames against a reference model.
module tb_tank_move_ctl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tank_move_ctl_if bus();

  tank_move_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers).
  int mx, my, mdir, msel, mcnt;
  bit mhit;

  typedef struct {
    logic [3:0] keys;   // {up, down, left, right}
    int         hmode;  // 0 none, 1 hit at tick, 2 hit mid-frame
    int         ex, ey, edir, esel;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 376; my = 268; mdir = 0; msel = 1; mcnt = 0; mhit = 0;
  endtask

  task automatic model_frame(input logic [3:0] k);
    int req, fw, fh;
    if (msel == 1 && mhit) begin
      msel = 0; mcnt = 120; mhit = 0;
    end else if (msel == 0 && mcnt > 1) begin
      mcnt = mcnt - 1;
    end else if (msel == 0) begin
      mx = 376; my = 268; mdir = 0; msel = 1; mcnt = 0;
    end else if (k != 4'b0000) begin
      if (k[3])      req = 0;
      else if (k[2]) req = 1;
      else if (k[1]) req = 2;
      else           req = 3;
      fw = (req >= 2) ? 64 : 48;
      fh = (req >= 2) ? 48 : 64;
      if (req != mdir) begin
        mdir = req;
        if (mx > 800 - fw) mx = 800 - fw;
        if (my > 600 - fh) my = 600 - fh;
      end else begin
        case (req)
          0: my = (my - 2 < 0) ? 0 : my - 2;
          1: my = (my + 2 > 600 - fh) ? 600 - fh : my + 2;
          2: mx = (mx - 2 < 0) ? 0 : mx - 2;
          default: mx = (mx + 2 > 800 - fw) ? 800 - fw : mx + 2;
        endcase
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.vblnk = 1'b0; bus.hit = 1'b0;
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One video frame: keys, optional hit, tick, wait for commit, compare with model.
  task automatic run_frame(input logic [3:0] k, input int hmode);
    int lat;
    @(negedge clk);
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
    if (hmode == 2) begin
      bus.hit = 1'b1;
      if (msel == 1) mhit = 1;
      @(negedge clk);
      bus.hit = 1'b0;
    end
    bus.vblnk = 1'b1;
    if (hmode == 1) begin
      bus.hit = 1'b1;
      if (msel == 1) mhit = 1;
    end
    @(negedge clk);
    bus.hit = 1'b0;
    lat = 0;
    while (bus.frame_done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 2);
    model_frame(k);
    check("posX", 32'(bus.posX), mx);
    check("posY", 32'(bus.posY), my);
    check("direction", 32'(bus.direction), mdir);
    check("select", 32'(bus.select), msel);
    $display("frame keys=%b hit=%0d -> x=%0d y=%0d dir=%0d sel=%0d",
             k, hmode, bus.posX, bus.posY, bus.direction, bus.select);
    @(negedge clk);
    check("frame_done_width", 32'(bus.frame_done), 0);
    bus.vblnk = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rk;
    int         rh;
    int         fd_seen;

    vecs[0] = '{4'b0001, 0, 376, 268, 3, 1};
    vecs[1] = '{4'b0001, 0, 378, 268, 3, 1};
    vecs[2] = '{4'b1010, 0, 378, 268, 0, 1};
    vecs[3] = '{4'b0000, 0, 378, 268, 0, 1};
    vecs[4] = '{4'b1000, 0, 378, 266, 0, 1};
    vecs[5] = '{4'b0100, 0, 378, 266, 1, 1};
    vecs[6] = '{4'b0100, 0, 378, 268, 1, 1};
    vecs[7] = '{4'b0010, 0, 378, 268, 2, 1};
    vecs[8] = '{4'b0010, 0, 376, 268, 2, 1};
    vecs[9] = '{4'b0001, 1, 376, 268, 2, 0};

    rst = 1'b1;
    bus.vblnk = 1'b0; bus.hit = 1'b0;
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 4'b0000;
    do_reset();
    @(negedge clk);
    check("reset_posX", 32'(bus.posX), 376);
    check("reset_posY", 32'(bus.posY), 268);
    check("reset_dir", 32'(bus.direction), 0);
    check("reset_select", 32'(bus.select), 1);
    check("reset_frame_done", 32'(bus.frame_done), 0);

    // Directed frame table.
    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].keys, vecs[i].hmode);
      check("tbl_posX", 32'(bus.posX), vecs[i].ex);
      check("tbl_posY", 32'(bus.posY), vecs[i].ey);
      check("tbl_dir", 32'(bus.direction), vecs[i].edir);
      check("tbl_select", 32'(bus.select), vecs[i].esel);
    end

    // Dead for 119 more frames (one hit while dead), then respawn.
    for (int i = 1; i < 120; i++) run_frame(4'(i), (i == 5) ? 2 : 0);
    check("dead_select", 32'(bus.select), 0);
    run_frame(4'b0001, 0);
    check("respawn_select", 32'(bus.select), 1);
    check("respawn_posX", 32'(bus.posX), 376);
    check("respawn_posY", 32'(bus.posY), 268);
    check("respawn_dir", 32'(bus.direction), 0);
    run_frame(4'b0001, 0);
    check("dead_hit_ignored", 32'(bus.select), 1);
    run_frame(4'b0000, 2);
    check("midframe_hit", 32'(bus.select), 0);

    // Screen edges.
    do_reset();
    for (int i = 0; i < 190; i++) run_frame(4'b0001, 0);
    check("edge_right", 32'(bus.posX), 736);
    for (int i = 0; i < 140; i++) run_frame(4'b0100, 0);
    check("edge_down", 32'(bus.posY), 536);
    for (int i = 0; i < 400; i++) run_frame(4'b0010, 0);
    check("edge_left", 32'(bus.posX), 0);
    for (int i = 0; i < 280; i++) run_frame(4'b1000, 0);
    check("edge_up", 32'(bus.posY), 0);

    // Reset during EVAL with a pending hit.
    @(negedge clk);
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 4'b0001;
    bus.vblnk = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.vblnk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_eval_posX", 32'(bus.posX), 376);
    check("rst_eval_posY", 32'(bus.posY), 268);
    check("rst_eval_dir", 32'(bus.direction), 0);
    check("rst_eval_select", 32'(bus.select), 1);
    fd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.frame_done === 1'b1) fd_seen++;
      @(negedge clk);
    end
    check("rst_eval_no_done", fd_seen, 0);
    run_frame(4'b0000, 0);
    check("rst_hit_discarded", 32'(bus.select), 1);

    // Random frames against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rk = 4'b0000;
      rh = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_frame(rk, rh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
